// File: rtl/area_classifier.sv
// Per-class mask area counter: accumulates each class over a frame, snapshots at the
// vsync edge, then scans the snapshot sequentially for the dominant class.
module area_classifier #(
  parameter int NCH      = 12,
  parameter int CNT_W    = 24,
  parameter int MIN_AREA = 1024,
  parameter int VS_POL   = 1,
  parameter int IDX_W    = $clog2(NCH + 1)
) (
  input  logic                 pixelclk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [NCH-1:0]       i_binary,
  input  logic                 i_hs,
  input  logic                 i_vs,
  input  logic                 i_de,
  output logic                 hs_r,
  output logic                 vs_r,
  output logic                 de_r,
  output logic [NCH*CNT_W-1:0] s_flat,
  output logic                 snap_valid,
  output logic [IDX_W-1:0]     best_idx,
  output logic [CNT_W-1:0]     best_area,
  output logic                 result_valid,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [IDX_W-1:0] NO_MATCH = IDX_W'(NCH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);
  localparam logic             VS_ACT   = (VS_POL != 0);
  // A threshold above the largest representable area can never be met.
  localparam bit               MIN_OVER = longint'(MIN_AREA) > ((longint'(1) << CNT_W) - 1);
  localparam logic [CNT_W-1:0] MIN_V    = MIN_OVER ? '1 : CNT_W'(MIN_AREA);

  logic [CNT_W-1:0] acc  [NCH];
  logic [CNT_W-1:0] snap [NCH];
  logic             first_frame;
  logic             boundary;
  logic             take_snap;
  logic [NCH-1:0]   hit;
  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] cand_idx;
  logic [CNT_W-1:0] cand_area;
  logic [CNT_W-1:0] cur;

  assign boundary  = (i_vs == VS_ACT) && (vs_r != VS_ACT);
  assign take_snap = boundary && !first_frame;
  assign hit       = (en && i_de) ? i_binary : '0;
  assign busy      = (state != IDLE);

  for (genvar g = 0; g < NCH; g++) begin : g_flat
    assign s_flat[g*CNT_W +: CNT_W] = snap[g];
  end

  always_ff @(posedge pixelclk or negedge rst_n) begin
    if (!rst_n) begin
      hs_r <= 1'b0;
      vs_r <= 1'b0;
      de_r <= 1'b0;
    end else begin
      hs_r <= i_hs;
      vs_r <= i_vs;
      de_r <= i_de;
    end
  end

  // A qualifying pixel in the boundary cycle starts the new frame's count at 1.
  always_ff @(posedge pixelclk or negedge rst_n) begin
    if (!rst_n) begin
      first_frame <= 1'b1;
      for (int k = 0; k < NCH; k++) acc[k] <= '0;
    end else begin
      if (boundary) first_frame <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        if (boundary)
          acc[k] <= CNT_W'(hit[k]);
        else if (hit[k] && (acc[k] != '1))
          acc[k] <= acc[k] + 1'b1;
      end
    end
  end

  always_ff @(posedge pixelclk or negedge rst_n) begin
    if (!rst_n) begin
      snap_valid <= 1'b0;
      for (int k = 0; k < NCH; k++) snap[k] <= '0;
    end else begin
      snap_valid <= take_snap;
      if (take_snap)
        for (int k = 0; k < NCH; k++) snap[k] <= acc[k];
    end
  end

  always_comb begin
    cur = '0;
    for (int k = 0; k < NCH; k++)
      if (idx == IDX_W'(k)) cur = snap[k];
  end

  always_ff @(posedge pixelclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // A fresh snapshot always restarts the scan, abandoning any scan in flight.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = IDLE;
      SCAN:    if (idx == LAST_IDX) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (take_snap) state_nxt = SCAN;
  end

  always_ff @(posedge pixelclk or negedge rst_n) begin
    if (!rst_n) begin
      idx          <= '0;
      cand_idx     <= NO_MATCH;
      cand_area    <= '0;
      best_idx     <= NO_MATCH;
      best_area    <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (take_snap) begin
        idx       <= '0;
        cand_idx  <= NO_MATCH;
        cand_area <= '0;
      end else begin
        case (state)
          SCAN: begin
            if (cur > cand_area) begin
              cand_area <= cur;
              cand_idx  <= idx;
            end
            idx <= idx + 1'b1;
          end
          DONE: begin
            result_valid <= 1'b1;
            best_area    <= cand_area;
            best_idx     <= (!MIN_OVER && (cand_area >= MIN_V)) ? cand_idx : NO_MATCH;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_area_classifier.sv
// Directed bench for area_classifier: three parameterisations share one stimulus
// stream; snapshot and result expectations are queued and popped as the DUTs report.
module tb_area_classifier;

  localparam int NCH   = 12;
  localparam int IDX_W = 4;
  localparam int FW    = NCH * 24;

  logic           pixelclk = 1'b0;
  logic           rst_n    = 1'b1;
  logic           en       = 1'b0;
  logic [NCH-1:0] i_binary = '0;
  logic           i_hs     = 1'b0;
  logic           i_vs     = 1'b0;
  logic           i_de     = 1'b0;

  logic             d_hs, d_vs, d_de, d_sv, d_rv, d_busy;
  logic [FW-1:0]    d_sflat;
  logic [IDX_W-1:0] d_idx;
  logic [23:0]      d_area;

  logic             m_hs, m_vs, m_de, m_sv, m_rv, m_busy;
  logic [FW-1:0]    m_sflat;
  logic [IDX_W-1:0] m_idx;
  logic [23:0]      m_area;

  logic             s_hs, s_vs, s_de, s_sv, s_rv, s_busy;
  logic [NCH*4-1:0] s_sflat;
  logic [IDX_W-1:0] s_idx;
  logic [3:0]       s_area;

  always #5 pixelclk = ~pixelclk;

  area_classifier u_def (
    .pixelclk(pixelclk), .rst_n(rst_n), .en(en), .i_binary(i_binary),
    .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de),
    .hs_r(d_hs), .vs_r(d_vs), .de_r(d_de), .s_flat(d_sflat), .snap_valid(d_sv),
    .best_idx(d_idx), .best_area(d_area), .result_valid(d_rv), .busy(d_busy)
  );

  area_classifier #(.MIN_AREA(16)) u_m16 (
    .pixelclk(pixelclk), .rst_n(rst_n), .en(en), .i_binary(i_binary),
    .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de),
    .hs_r(m_hs), .vs_r(m_vs), .de_r(m_de), .s_flat(m_sflat), .snap_valid(m_sv),
    .best_idx(m_idx), .best_area(m_area), .result_valid(m_rv), .busy(m_busy)
  );

  area_classifier #(.CNT_W(4)) u_sat (
    .pixelclk(pixelclk), .rst_n(rst_n), .en(en), .i_binary(i_binary),
    .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de),
    .hs_r(s_hs), .vs_r(s_vs), .de_r(s_de), .s_flat(s_sflat), .snap_valid(s_sv),
    .best_idx(s_idx), .best_area(s_area), .result_valid(s_rv), .busy(s_busy)
  );

  typedef struct packed {
    logic [FW-1:0]    flat24;
    logic [NCH*4-1:0] flat4;
  } snap_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx_def;
    logic [IDX_W-1:0] idx_m16;
    logic [23:0]      area;
  } res_t;

  snap_t snap_q[$];
  res_t  res_q[$];
  snap_t ms;
  res_t  mr;
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cycle = 0;
  int    bnd_cycle = 0;
  int    stim_cnt[NCH];
  logic  rv_prev = 1'b0;

  always @(posedge pixelclk) cycle <= cycle + 1;

  task automatic check_output(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pixelclk);
    #1;
  endtask

  task automatic set_stim(input int k0, input int c0, input int k1, input int c1);
    for (int k = 0; k < NCH; k++)
      stim_cnt[k] = (k == k0) ? c0 : ((k == k1) ? c1 : 0);
  endtask

  task automatic push_snap(input int k0, input int c0, input int k1, input int c1);
    snap_t s;
    int    c;
    s = '0;
    for (int k = 0; k < NCH; k++) begin
      c = (k == k0) ? c0 : ((k == k1) ? c1 : 0);
      s.flat24[k*24 +: 24] = 24'(c);
      s.flat4[k*4 +: 4]    = (c > 15) ? 4'd15 : 4'(c);
    end
    snap_q.push_back(s);
  endtask

  task automatic push_res(input int idx_def, input int idx_m16, input int area);
    res_t r;
    r.idx_def = IDX_W'(idx_def);
    r.idx_m16 = IDX_W'(idx_m16);
    r.area    = 24'(area);
    res_q.push_back(r);
  endtask

  // Lines of 8 pixels separated by a two-cycle blank with an hsync pulse.
  task automatic apply_stimulus(input int npix, input int en_pix);
    for (int p = 0; p < npix; p++) begin
      if (p > 0 && p % 8 == 0) begin
        i_de = 1'b0; i_binary = '0; i_hs = 1'b1;
        tick();
        i_hs = 1'b0;
        check_output("hs_r", FW'(d_hs), FW'(1));
        tick();
      end
      en   = (p < en_pix);
      i_de = 1'b1;
      for (int k = 0; k < NCH; k++) i_binary[k] = (p < stim_cnt[k]);
      tick();
    end
    i_de = 1'b0; i_binary = '0; en = 1'b1;
    repeat (3) tick();
  endtask

  task automatic do_boundary(input logic [NCH-1:0] bmask);
    i_vs = 1'b1; i_de = |bmask; i_binary = bmask;
    bnd_cycle = cycle;
    tick();
    i_vs = 1'b0; i_de = 1'b0; i_binary = '0;
    check_output("vs_r_high", FW'(d_vs), FW'(1));
    tick();
    check_output("vs_r_low", FW'(d_vs), FW'(0));
  endtask

  // Scoreboard side: pop the oldest expectation whenever a DUT reports.
  always @(negedge pixelclk) begin
    if (rv_prev) check_output("rv_width", FW'(m_rv), FW'(0));
    rv_prev <= m_rv;
    if (m_sv === 1'b1) begin
      check_output("snap_pending", FW'(snap_q.size() != 0), FW'(1));
      if (snap_q.size() != 0) begin
        ms = snap_q.pop_front();
        check_output("snap_def", d_sflat, ms.flat24);
        check_output("snap_m16", m_sflat, ms.flat24);
        check_output("snap_sat", FW'(s_sflat), FW'(ms.flat4));
        check_output("snap_def_sv", FW'(d_sv), FW'(1));
      end
    end
    if (m_rv === 1'b1) begin
      check_output("res_pending", FW'(res_q.size() != 0), FW'(1));
      if (res_q.size() != 0) begin
        mr = res_q.pop_front();
        check_output("idx_m16", FW'(m_idx), FW'(mr.idx_m16));
        check_output("area_m16", FW'(m_area), FW'(mr.area));
        check_output("idx_def", FW'(d_idx), FW'(mr.idx_def));
        check_output("area_def", FW'(d_area), FW'(mr.area));
        check_output("rv_def", FW'(d_rv), FW'(1));
        check_output("latency", FW'(cycle - bnd_cycle), FW'(14));
      end
    end
  end

  initial begin
    #2 rst_n = 1'b0;
    en = 1'b1;
    repeat (3) tick();
    check_output("rst_idx", FW'(d_idx), FW'(12));
    check_output("rst_area", FW'(d_area), FW'(0));
    check_output("rst_rv", FW'(d_rv), FW'(0));
    check_output("rst_sv", FW'(d_sv), FW'(0));
    check_output("rst_busy", FW'(d_busy), FW'(0));
    check_output("rst_sflat", d_sflat, FW'(0));
    rst_n = 1'b1;
    tick();

    // Partial frame after reset is discarded at the first boundary.
    set_stim(0, 32, -1, 0);
    apply_stimulus(32, 32);
    do_boundary('0);
    apply_stimulus(32, 32);
    push_snap(0, 32, -1, 0);
    push_res(12, 0, 32);
    do_boundary('0);

    set_stim(3, 20, 7, 25);
    apply_stimulus(32, 32);
    push_snap(3, 20, 7, 25);
    push_res(12, 7, 25);
    do_boundary('0);

    set_stim(2, 30, 9, 30);
    apply_stimulus(32, 32);
    push_snap(2, 30, 9, 30);
    push_res(12, 2, 30);
    do_boundary('0);

    set_stim(5, 32, -1, 0);
    apply_stimulus(32, 16);
    push_snap(5, 16, -1, 0);
    push_res(12, 5, 16);
    do_boundary('0);

    apply_stimulus(32, 0);
    push_snap(0, 0, -1, 0);
    push_res(12, 12, 0);
    do_boundary(12'h002);

    // Saturation frame; also carries the pixel seen in the boundary cycle above.
    set_stim(0, 40, -1, 0);
    apply_stimulus(40, 40);
    push_snap(0, 40, 1, 1);
    push_res(12, 0, 40);
    do_boundary('0);

    // Second boundary lands mid-scan; only its result may appear.
    set_stim(4, 20, -1, 0);
    apply_stimulus(32, 32);
    push_snap(4, 20, -1, 0);
    do_boundary('0);
    i_de = 1'b1; i_binary = 12'h040;
    repeat (3) tick();
    i_de = 1'b0; i_binary = '0;
    check_output("busy_scan", FW'(m_busy), FW'(1));
    push_snap(6, 3, -1, 0);
    push_res(12, 12, 3);
    do_boundary('0);
    repeat (20) tick();

    set_stim(8, 32, -1, 0);
    apply_stimulus(32, 32);
    push_snap(8, 32, -1, 0);
    do_boundary('0);
    repeat (3) tick();
    check_output("busy_pre_rst", FW'(d_busy), FW'(1));
    rst_n = 1'b0;
    #1;
    check_output("mid_rst_busy", FW'(d_busy), FW'(0));
    check_output("mid_rst_idx", FW'(d_idx), FW'(12));
    check_output("mid_rst_area", FW'(d_area), FW'(0));
    check_output("mid_rst_sflat", m_sflat, FW'(0));
    check_output("mid_rst_idx_m16", FW'(m_idx), FW'(12));
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (25) tick();

    check_output("snap_q_empty", FW'(snap_q.size()), FW'(0));
    check_output("res_q_empty", FW'(res_q.size()), FW'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
